// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between execute and the data memory port.
//
// Accepts one access per req_valid/req_ready handshake, drives a word-addressed
// bus with byte enables and a req/ack handshake, and returns a one-cycle response
// with the realigned, sign/zero-extended load result and a fault code.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_*/o_req_ready     access request from execute (we, size, addr, wdata, rd)
//   o_mem_*                 bus request (req, we, word addr, byte enables, wdata)
//   i_mem_ack/i_mem_rdata   bus completion and read word (valid with ack)
//   o_rsp_*                 response pulse, load data, echoed rd tag, fault code
//                           (0 none, 1 misaligned, 2 illegal size, 3 timeout)
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [4:0]  o_rsp_rd,
  output logic [1:0]  o_rsp_fault
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [1:0] FaultNone  = 2'd0;
  localparam logic [1:0] FaultAlign = 2'd1;
  localparam logic [1:0] FaultSize  = 2'd2;
  localparam logic [1:0] FaultTime  = 2'd3;

  // Count value on the last ACCESS cycle before a timeout is declared.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  state_e      r_state,       w_state_next;
  logic [7:0]  r_cnt,         w_cnt_next;
  logic        r_we,          w_we_next;
  logic [2:0]  r_size,        w_size_next;
  logic [1:0]  r_off,         w_off_next;
  logic        r_req_ready,   w_req_ready_next;
  logic        r_mem_req,     w_mem_req_next;
  logic        r_mem_we,      w_mem_we_next;
  logic [31:0] r_mem_addr,    w_mem_addr_next;
  logic [3:0]  r_mem_be,      w_mem_be_next;
  logic [31:0] r_mem_wdata,   w_mem_wdata_next;
  logic        r_rsp_valid,   w_rsp_valid_next;
  logic [31:0] r_rsp_rdata,   w_rsp_rdata_next;
  logic [4:0]  r_rsp_rd,      w_rsp_rd_next;
  logic [1:0]  r_rsp_fault,   w_rsp_fault_next;

  // Request decode
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_illegal    = (i_req_size > 3'd4);
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = 32'd0;
    unique case (i_req_size)
      3'd0, 3'd3: begin
        w_be    = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      3'd1, 3'd4: begin
        w_misaligned = i_req_addr[0];
        w_be         = 4'b0011 << i_req_addr[1:0];
        w_wdata      = {2{i_req_wdata[15:0]}};
      end
      3'd2: begin
        w_misaligned = (i_req_addr[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = i_req_wdata;
      end
      default: ;
    endcase
  end

  // Load realignment from the latched byte offset and size
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  always_comb begin
    w_shifted = i_mem_rdata >> {r_off, 3'b000};
    w_load    = 32'd0;
    unique case (r_size)
      3'd0:    w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd2:    w_load = w_shifted;
      3'd3:    w_load = {24'd0, w_shifted[7:0]};
      3'd4:    w_load = {16'd0, w_shifted[15:0]};
      default: w_load = 32'd0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_we_next        = r_we;
    w_size_next      = r_size;
    w_off_next       = r_off;
    w_req_ready_next = r_req_ready;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_be_next    = r_mem_be;
    w_mem_wdata_next = r_mem_wdata;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_rd_next    = r_rsp_rd;
    w_rsp_fault_next = r_rsp_fault;

    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_we_next        = i_req_we;
          w_size_next      = i_req_size;
          w_off_next       = i_req_addr[1:0];
          w_rsp_rd_next    = i_req_rd;
          w_cnt_next       = 8'd0;
          w_req_ready_next = 1'b0;
          if (w_illegal || w_misaligned) begin
            // Faulted requests go straight to the response, never touching the bus.
            w_state_next     = StResp;
            w_rsp_valid_next = 1'b1;
            w_rsp_rdata_next = 32'd0;
            w_rsp_fault_next = w_illegal ? FaultSize : FaultAlign;
          end else begin
            w_state_next     = StAccess;
            w_mem_req_next   = 1'b1;
            w_mem_we_next    = i_req_we;
            w_mem_addr_next  = {i_req_addr[31:2], 2'b00};
            w_mem_be_next    = w_be;
            w_mem_wdata_next = w_wdata;
          end
        end
      end
      StAccess: begin
        // Ack takes priority over a timeout in the same cycle.
        if (i_mem_ack) begin
          w_state_next     = StResp;
          w_mem_req_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_we ? 32'd0 : w_load;
          w_rsp_fault_next = FaultNone;
        end else if (r_cnt == TimeoutLast) begin
          w_state_next     = StResp;
          w_mem_req_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = 32'd0;
          w_rsp_fault_next = FaultTime;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      StResp: begin
        w_state_next     = StIdle;
        w_req_ready_next = 1'b1;
      end
      default: begin
        w_state_next     = StIdle;
        w_req_ready_next = 1'b1;
        w_mem_req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_we        <= 1'b0;
      r_size      <= 3'd0;
      r_off       <= 2'd0;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_rd    <= 5'd0;
      r_rsp_fault <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_we        <= w_we_next;
      r_size      <= w_size_next;
      r_off       <= w_off_next;
      r_req_ready <= w_req_ready_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_be    <= w_mem_be_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_rd    <= w_rsp_rd_next;
      r_rsp_fault <= w_rsp_fault_next;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_rd    = r_rsp_rd;
  assign o_rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a short timeout so timeouts are cheap.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_size  (req_size),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_rd    (req_rd),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_rd    (rsp_rd),
    .o_rsp_fault (rsp_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned sz_bytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [1:0] exp_fault(input logic [2:0] s, input logic [31:0] a);
    if (s > 3'd4) return 2'd2;
    if ((a % sz_bytes(s)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
    int unsigned nb = sz_bytes(s);
    int unsigned lane = a % 4;
    return 4'(((1 << nb) - 1) << lane);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] r;
    int unsigned nb = sz_bytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] rd_word);
    int unsigned nb = sz_bytes(s);
    int unsigned lane = a % 4;
    longint v;
    v = {32'd0, rd_word};
    v = (v >> (8 * lane)) & ((longint'(1) << (8 * nb)) - 1);
    if ((s == 3'd0 || s == 3'd1) && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // ---------------- one access ----------------
  // ack_at: ACCESS cycle (1-based) on which ack is given; > TO means never.
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int ack_at,
                           input logic [31:0] rdata);
    int guard = 0;
    logic [1:0] f;
    bit acked = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before", req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 0; req_we = $urandom; req_size = 3'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_rd = 5'($urandom);
    f = exp_fault(size, addr);
    if (f != 2'd0) begin
      check("fault_no_memreq", mem_req, 0);
      check("fault_rsp_valid", rsp_valid, 1);
      check("fault_code", rsp_fault, f);
      check("fault_rdata", rsp_rdata, 0);
      check("fault_rd", rsp_rd, rd);
      check("fault_ready_low", req_ready, 0);
    end else begin
      check("acc_mem_req", mem_req, 1);
      check("acc_mem_we", mem_we, we);
      check("acc_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("acc_mem_be", mem_be, exp_be(size, addr));
      check("acc_mem_wdata", mem_wdata, exp_wdata(size, wdata));
      check("acc_ready_low", req_ready, 0);
      check("acc_no_rsp", rsp_valid, 0);
      for (int n = 1; n <= int'(TO); n++) begin
        mem_ack = (n == ack_at);
        mem_rdata = (n == ack_at) ? rdata : $urandom;
        @(posedge clk); #1;
        mem_ack = 0;
        mem_rdata = $urandom;
        if (n == ack_at) begin
          acked = 1;
          break;
        end
        if (n < int'(TO)) begin
          check("hold_mem_req", mem_req, 1);
          check("hold_mem_be", mem_be, exp_be(size, addr));
          check("hold_no_rsp", rsp_valid, 0);
        end
      end
      check("done_mem_req_low", mem_req, 0);
      check("done_rsp_valid", rsp_valid, 1);
      check("done_fault", rsp_fault, acked ? 2'd0 : 2'd3);
      check("done_rdata", rsp_rdata, (acked && !we) ? exp_load(size, addr, rdata) : 32'd0);
      check("done_rd", rsp_rd, rd);
    end
    @(posedge clk); #1;
    check("after_rsp_pulse_low", rsp_valid, 0);
    check("after_ready_high", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    req_rd = 0; mem_ack = 0; mem_rdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_rd", rsp_rd, 0);
    check("rst_rsp_fault", rsp_fault, 0);

    // Directed cases
    do_access(0, 3'd0, 32'h0000_1003, 32'h0, 5'd3, 1, 32'h80FF_1234);
    do_access(0, 3'd4, 32'h0000_2002, 32'h0, 5'd4, 1, 32'hBEEF_0000);
    do_access(0, 3'd1, 32'h0000_2002, 32'h0, 5'd5, 2, 32'hBEEF_0000);
    do_access(1, 3'd3, 32'h0000_0001, 32'h0000_00A5, 5'd6, 4, 32'h1234_5678);
    do_access(0, 3'd2, 32'h0000_0002, 32'h0, 5'd7, 1, 32'h0);
    do_access(0, 3'd6, 32'h0000_0000, 32'h0, 5'd8, 1, 32'h0);
    do_access(0, 3'd2, 32'h0000_0040, 32'h0, 5'd9, TO + 1, 32'hDEAD_BEEF);
    do_access(0, 3'd2, 32'h0000_0040, 32'h0, 5'd10, TO, 32'hCAFE_F00D);
    do_access(1, 3'd1, 32'h0000_0102, 32'h0000_9876, 5'd11, 2, 32'h0);

    // Ack while idle is ignored
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 0;
    check("idle_ack_no_rsp", rsp_valid, 0);
    check("idle_ack_ready", req_ready, 1);
    check("idle_ack_no_memreq", mem_req, 0);

    // Reset during ACCESS with a simultaneous ack
    req_valid = 1; req_we = 0; req_size = 3'd2; req_addr = 32'h100; req_rd = 5'd12;
    @(posedge clk); #1;
    req_valid = 0;
    check("rst_acc_mem_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1111_2222; rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_ack = 0;
    check("rst_acc_mem_req_low", mem_req, 0);
    check("rst_acc_no_rsp", rsp_valid, 0);
    check("rst_acc_ready", req_ready, 1);
    check("rst_acc_be", mem_be, 0);
    @(posedge clk); #1;
    check("rst_acc_no_rsp_late", rsp_valid, 0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom), int'($urandom_range(1, TO + 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the execute stage and the data memory port. It accepts one access per handshake: ALU-computed address, store data, size code and direction. It drives a word-addressed memory bus with byte enables and a req/ack handshake. Load data is realigned and sign/zero-extended, then returned to writeback (the WB_DATA_MEM source). Misaligned, illegal-size and timed-out accesses are reported instead of performed.

## Interface
- TIMEOUT_CYC, 255: max cycles mem_req may stay high without mem_ack before a timeout fault (1..255)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute presents an access
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  0 byte signed, 1 half signed, 2 word, 3 byte unsigned, 4 half unsigned, 5-7 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- req_rd  in  5  destination register tag, echoed on response
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  bus write
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; mem_rdata valid same cycle
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and faults
- rsp_rd  out  5  latched req_rd
- rsp_fault  out  2  0 none, 1 misaligned, 2 illegal size, 3 timeout

## Operation
- States: IDLE, ACCESS, RESP. Registered outputs only.
- IDLE: req_ready=1. On accept, latch all request fields. The next state depends on the request:
  - illegal size -> RESP, fault 2;
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP, fault 1;
  - otherwise -> ACCESS, with mem_req=1 from the next cycle.
- Faulted requests never assert mem_req.
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata are stable. The wait counter increments each cycle with no ack.
  - mem_ack -> capture mem_rdata, drop mem_req, go to RESP with fault 0.
  - Counter reaches TIMEOUT_CYC without ack -> drop mem_req, go to RESP with fault 3.
  - mem_ack in the same cycle as timeout: ack wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACCESS and RESP.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: w = mem_rdata >> (8*addr[1:0]).
  - size 0: sext w[7:0]; size 1: sext w[15:0]; size 2: w.
  - size 3: zext w[7:0]; size 4: zext w[15:0].
- mem_ack outside ACCESS is ignored.

## Timing
- Reset values: req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_rd=0, rsp_fault=0; state IDLE, counter 0.
- rst high in any state: IDLE at the next edge; mem_req low; pending ack discarded; no rsp_valid.
- Accept at edge 0: mem_req high after edge 0.
- Ack sampled at edge k: rsp_valid high for the cycle after edge k; next accept possible at edge k+2.
- Ack in the first ACCESS cycle: rsp_valid 2 cycles after accept; minimum throughput one access per 3 cycles.
- Fault path: rsp_valid 1 cycle after accept.
- Timeout: mem_req high for exactly TIMEOUT_CYC cycles, then rsp_valid the next cycle.
- Counter is 8 bits and clears on every accept; it never wraps.

## Test plan
- Load byte signed, addr 0x1003, mem_rdata 0x80FF_1234, ack after 1 cycle -> mem_addr 0x1000, mem_be 4'b1000, rsp_rdata 0xFFFF_FF80, fault 0, rsp_valid 2 cycles after accept.
- Load half unsigned, addr 0x2002, mem_rdata 0xBEEF_0000 -> mem_be 4'b1100, rsp_rdata 0x0000_BEEF; same access as half signed -> 0xFFFF_BEEF.
- Store byte, addr 0x0001, wdata 0x0000_00A5, ack delayed 3 cycles -> mem_we 1, mem_be 4'b0010, mem_wdata 0xA5A5_A5A5, mem_req high 4 cycles, rsp_rdata 0.
- Word load at 0x0002, then size 6 at 0x0000 -> no mem_req; rsp_fault 1, then rsp_fault 2, each rsp_valid 1 cycle after accept.
- TIMEOUT_CYC=4, no ack -> mem_req high exactly 4 cycles, rsp_fault 3. Repeat with ack on the 4th cycle -> fault 0, data returned.
- rst asserted during ACCESS with ack the same cycle -> IDLE, mem_req 0, no rsp_valid, req_ready 1 next cycle.
